// File: rtl/ofs_plat_avalon_mem_rdwr_allowance_sink_pkg.sv
// Shared helpers for the Avalon rdwr allowance sink: the waitrequest
// threshold and the legality test for the FIFO geometry.
// Optional feature macro (used by the sub-module and top):
//    OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN
package ofs_plat_avalon_allowance_sink_pkg;

   // Occupancy at which the source must see waitrequest. Once waitrequest is
   // up the source may still land ALLOWANCE more entries, so asserting it at
   // DEPTH-ALLOWANCE leaves exactly enough room for them.
   function automatic int waitreqThreshold(input int depth, input int allowance);
      return depth - allowance;
   endfunction

   // A FIFO geometry is usable when DEPTH is a power of two (pointers wrap
   // for free) and DEPTH exceeds the allowance (threshold at least 1).
   function automatic bit paramsValid(input int depth, input int allowance);
      return (depth > 0) &&
             ((depth & (depth - 1)) == 0) &&
             (depth > allowance);
   endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_rdwr_allowance_sink_if.sv
// Avalon rdwr bus: an independent read channel and write channel, each
// with its own waitrequest. The master modport issues requests, the slave
// modport accepts them and returns responses.
interface ofs_plat_avalon_mem_rdwr_allowance_sink_if #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_CNT_WIDTH = 7
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   // Read request channel and read response
   logic                       rd_read;
   logic [ADDR_WIDTH-1:0]      rd_address;
   logic [BURST_CNT_WIDTH-1:0] rd_burstcount;
   logic [BE_WIDTH-1:0]        rd_byteenable;
   logic                       rd_waitrequest;
   logic [DATA_WIDTH-1:0]      rd_readdata;
   logic                       rd_readdatavalid;

   // Write beat channel and write response
   logic                       wr_write;
   logic [ADDR_WIDTH-1:0]      wr_address;
   logic [BURST_CNT_WIDTH-1:0] wr_burstcount;
   logic [DATA_WIDTH-1:0]      wr_writedata;
   logic [BE_WIDTH-1:0]        wr_byteenable;
   logic                       wr_waitrequest;
   logic                       wr_writeresponsevalid;

   modport master (
      output rd_read, rd_address, rd_burstcount, rd_byteenable,
      input  rd_waitrequest, rd_readdata, rd_readdatavalid,
      output wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable,
      input  wr_waitrequest, wr_writeresponsevalid
   );

   modport slave (
      input  rd_read, rd_address, rd_burstcount, rd_byteenable,
      output rd_waitrequest, rd_readdata, rd_readdatavalid,
      input  wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable,
      output wr_waitrequest, wr_writeresponsevalid
   );

endinterface

// File: rtl/ofs_plat_avalon_mem_rdwr_allowance_sink_fifo.sv
// Width-parameterized FIFO for one channel of the allowance sink. Pushes
// are unconditional (the source ignores waitrequest within its allowance),
// so backpressure is a registered almost-full flag rather than a ready.
// The caller qualifies pop_i: it must only pop when count_o is non-zero.
// With OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN defined, a push into a full
// FIFO that is not matched by a pop is dropped and flagged sticky.
module ofs_plat_avalon_allowance_fifo
   import ofs_plat_avalon_allowance_sink_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int ALLOWANCE = 4
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       almost_full_o,
   output logic                       overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] THRESHOLD = CNT_W'(waitreqThreshold(DEPTH, ALLOWANCE));
   localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             almostFull_q, almostFull_d;
   logic             pushEn;

`ifdef OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN
   logic overflow_q, overflow_d;

   // A push into a full FIFO only fits if a pop frees the head this cycle.
   assign pushEn     = push_i && !((count_q == FULL) && !pop_i);
   assign overflow_d = overflow_q || (push_i && !pushEn);

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow_o = overflow_q;
`else
   assign pushEn     = push_i;
   assign overflow_o = 1'b0;
`endif

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (pushEn) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({pushEn, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      almostFull_d = (count_d >= THRESHOLD);
   end

   // State registers; waitrequest comes up asserted out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         almostFull_q <= 1'b1;
      end else begin
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         almostFull_q <= almostFull_d;
      end
   end

   // Entry storage; data needs no reset because the pointers gate it.
   always_ff @(posedge clk) begin
      if (pushEn && !reset) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   assign data_o        = mem_q[rdPtr_q];
   assign count_o       = count_q;
   assign almost_full_o = almostFull_q;

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_allowance_sink.sv
// Terminates an Avalon rdwr pipeline running under a waitrequest allowance
// and drives a strict zero-allowance sink. Read requests and write beats
// are buffered in independent FIFOs; there is no read/write ordering.
// Responses are wired straight through from sink to source.
// Optional feature macro: OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN enables
// full-FIFO push dropping and the sticky rd_overflow/wr_overflow flags;
// without it both flags are constant 0.
module ofs_plat_avalon_mem_rdwr_allowance_sink
   import ofs_plat_avalon_allowance_sink_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int ALLOWANCE       = 4,
   parameter int DEPTH           = 8
)
(
   input  logic clk,
   input  logic reset,
   ofs_plat_avalon_mem_rdwr_allowance_sink_if.slave  src,
   ofs_plat_avalon_mem_rdwr_allowance_sink_if.master snk,
   output logic rd_overflow,
   output logic wr_overflow
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int RD_W     = ADDR_WIDTH + BURST_CNT_WIDTH + BE_WIDTH;
   localparam int WR_W     = ADDR_WIDTH + BURST_CNT_WIDTH + DATA_WIDTH + BE_WIDTH;
   localparam int CNT_W    = $clog2(DEPTH) + 1;

   // Refuse to elaborate a geometry the FIFOs cannot support.
   if (!paramsValid(DEPTH, ALLOWANCE)) begin : g_paramCheck
      $error("ofs_plat_avalon_mem_rdwr_allowance_sink: DEPTH must be a power of two greater than ALLOWANCE");
   end

   // ---------------- Read request channel ----------------
   logic [RD_W-1:0]  rdPushData;
   logic [RD_W-1:0]  rdHeadData;
   logic [CNT_W-1:0] rdCount;
   logic             rdValid;
   logic             rdPop;
   logic             rdAlmostFull;
   logic             rdOverflow;

   assign rdPushData = {src.rd_address, src.rd_burstcount, src.rd_byteenable};
   assign rdValid    = (rdCount != '0);
   assign rdPop      = rdValid && !snk.rd_waitrequest;

   ofs_plat_avalon_allowance_fifo #(
      .WIDTH     (RD_W),
      .DEPTH     (DEPTH),
      .ALLOWANCE (ALLOWANCE)
   ) u_rdFifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (src.rd_read),
      .data_i        (rdPushData),
      .pop_i         (rdPop),
      .data_o        (rdHeadData),
      .count_o       (rdCount),
      .almost_full_o (rdAlmostFull),
      .overflow_o    (rdOverflow)
   );

   assign snk.rd_read = rdValid;
   assign {snk.rd_address, snk.rd_burstcount, snk.rd_byteenable} = rdHeadData;
   assign src.rd_waitrequest = rdAlmostFull;

   // ---------------- Write beat channel ----------------
   logic [WR_W-1:0]  wrPushData;
   logic [WR_W-1:0]  wrHeadData;
   logic [CNT_W-1:0] wrCount;
   logic             wrValid;
   logic             wrPop;
   logic             wrAlmostFull;
   logic             wrOverflow;

   assign wrPushData = {src.wr_address, src.wr_burstcount, src.wr_writedata, src.wr_byteenable};
   assign wrValid    = (wrCount != '0);
   assign wrPop      = wrValid && !snk.wr_waitrequest;

   ofs_plat_avalon_allowance_fifo #(
      .WIDTH     (WR_W),
      .DEPTH     (DEPTH),
      .ALLOWANCE (ALLOWANCE)
   ) u_wrFifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (src.wr_write),
      .data_i        (wrPushData),
      .pop_i         (wrPop),
      .data_o        (wrHeadData),
      .count_o       (wrCount),
      .almost_full_o (wrAlmostFull),
      .overflow_o    (wrOverflow)
   );

   assign snk.wr_write = wrValid;
   assign {snk.wr_address, snk.wr_burstcount, snk.wr_writedata, snk.wr_byteenable} = wrHeadData;
   assign src.wr_waitrequest = wrAlmostFull;

   // ---------------- Responses and status ----------------
   assign src.rd_readdata           = snk.rd_readdata;
   assign src.rd_readdatavalid      = snk.rd_readdatavalid;
   assign src.wr_writeresponsevalid = snk.wr_writeresponsevalid;

   assign rd_overflow = rdOverflow;
   assign wr_overflow = wrOverflow;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_allowance_sink.sv
// Directed bench for the Avalon rdwr allowance sink (DEPTH=8, ALLOWANCE=4).
// The overflow scenario follows OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN.
module tb_ofs_plat_avalon_mem_rdwr_allowance_sink;

   localparam int ADDR_WIDTH      = 32;
   localparam int DATA_WIDTH      = 512;
   localparam int BURST_CNT_WIDTH = 7;
   localparam int BE_WIDTH        = DATA_WIDTH / 8;
   localparam int ALLOWANCE       = 4;
   localparam int DEPTH           = 8;
   localparam int THRESH          = DEPTH - ALLOWANCE;

   logic clk = 1'b0;
   logic reset;
   logic rd_overflow;
   logic wr_overflow;

   int checkCount = 0;
   int errorCount = 0;

   ofs_plat_avalon_mem_rdwr_allowance_sink_if #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_CNT_WIDTH(BURST_CNT_WIDTH)
   ) srcIf ();

   ofs_plat_avalon_mem_rdwr_allowance_sink_if #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_CNT_WIDTH(BURST_CNT_WIDTH)
   ) snkIf ();

   ofs_plat_avalon_mem_rdwr_allowance_sink #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .BURST_CNT_WIDTH (BURST_CNT_WIDTH),
      .ALLOWANCE       (ALLOWANCE),
      .DEPTH           (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .src         (srcIf),
      .snk         (snkIf),
      .rd_overflow (rd_overflow),
      .wr_overflow (wr_overflow)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Quiet source, ready sink, no responses
   task automatic applyIdle();
      srcIf.rd_read               = 1'b0;
      srcIf.rd_address            = '0;
      srcIf.rd_burstcount         = '0;
      srcIf.rd_byteenable         = '0;
      srcIf.wr_write              = 1'b0;
      srcIf.wr_address            = '0;
      srcIf.wr_burstcount         = '0;
      srcIf.wr_writedata          = '0;
      srcIf.wr_byteenable         = '0;
      snkIf.rd_waitrequest        = 1'b0;
      snkIf.rd_readdata           = '0;
      snkIf.rd_readdatavalid      = 1'b0;
      snkIf.wr_waitrequest        = 1'b0;
      snkIf.wr_writeresponsevalid = 1'b0;
   endtask

   task automatic test_reset();
      applyIdle();
      reset = 1'b1;
      srcIf.rd_read  = 1'b1;
      srcIf.wr_write = 1'b1;
      cycle();
      cycle();
      checkCount++;
      if (srcIf.rd_waitrequest !== 1'b1) begin
         errorCount++; $display("[TB] FAIL reset_rd_waitreq got %b want 1", srcIf.rd_waitrequest);
      end
      checkCount++;
      if (srcIf.wr_waitrequest !== 1'b1) begin
         errorCount++; $display("[TB] FAIL reset_wr_waitreq got %b want 1", srcIf.wr_waitrequest);
      end
      checkCount++;
      if (snkIf.rd_read !== 1'b0) begin
         errorCount++; $display("[TB] FAIL reset_snk_rd_read got %b want 0", snkIf.rd_read);
      end
      checkCount++;
      if (snkIf.wr_write !== 1'b0) begin
         errorCount++; $display("[TB] FAIL reset_snk_wr_write got %b want 0", snkIf.wr_write);
      end
      checkCount++;
      if ({rd_overflow, wr_overflow} !== 2'b00) begin
         errorCount++; $display("[TB] FAIL reset_overflow got %b want 00", {rd_overflow, wr_overflow});
      end
      srcIf.rd_read  = 1'b0;
      srcIf.wr_write = 1'b0;
      reset = 1'b0;
      cycle();
      checkCount++;
      if ({srcIf.rd_waitrequest, srcIf.wr_waitrequest} !== 2'b00) begin
         errorCount++; $display("[TB] FAIL post_reset_waitreq got %b want 00",
                                {srcIf.rd_waitrequest, srcIf.wr_waitrequest});
      end
      checkCount++;
      if ({snkIf.rd_read, snkIf.wr_write} !== 2'b00) begin
         errorCount++; $display("[TB] FAIL post_reset_snk_req got %b want 00",
                                {snkIf.rd_read, snkIf.wr_write});
      end
   endtask

   task automatic test_passthrough();
      logic [DATA_WIDTH-1:0] pattern;
      pattern = {16{32'hC0DE_0000}} ^ DATA_WIDTH'(32'h1234_5678);
      snkIf.rd_readdata           = pattern;
      snkIf.rd_readdatavalid      = 1'b1;
      snkIf.wr_writeresponsevalid = 1'b1;
      #1;
      checkCount++;
      if (srcIf.rd_readdata !== pattern) begin
         errorCount++; $display("[TB] FAIL pass_readdata got %h want %h", srcIf.rd_readdata, pattern);
      end
      checkCount++;
      if ({srcIf.rd_readdatavalid, srcIf.wr_writeresponsevalid} !== 2'b11) begin
         errorCount++; $display("[TB] FAIL pass_valids_hi got %b want 11",
                                {srcIf.rd_readdatavalid, srcIf.wr_writeresponsevalid});
      end
      snkIf.rd_readdatavalid      = 1'b0;
      snkIf.wr_writeresponsevalid = 1'b0;
      #1;
      checkCount++;
      if ({srcIf.rd_readdatavalid, srcIf.wr_writeresponsevalid} !== 2'b00) begin
         errorCount++; $display("[TB] FAIL pass_valids_lo got %b want 00",
                                {srcIf.rd_readdatavalid, srcIf.wr_writeresponsevalid});
      end
      cycle();
   endtask

   task automatic test_idle_reads();
      logic [ADDR_WIDTH-1:0] expAddr;
      logic [BE_WIDTH-1:0]   expBe;
      applyIdle();
      for (int i = 0; i < 4; i++) begin
         expAddr = ADDR_WIDTH'(32'h100 + i);
         expBe   = 64'h0F0F_0000_0000_0000 | 64'(i);
         srcIf.rd_read       = 1'b1;
         srcIf.rd_address    = expAddr;
         srcIf.rd_burstcount = BURST_CNT_WIDTH'(i + 1);
         srcIf.rd_byteenable = expBe;
         cycle();
         checkCount++;
         if (snkIf.rd_read !== 1'b1 || snkIf.rd_address !== expAddr) begin
            errorCount++; $display("[TB] FAIL idle_rd[%0d] got read=%b addr=%h want read=1 addr=%h",
                                   i, snkIf.rd_read, snkIf.rd_address, expAddr);
         end
         checkCount++;
         if (snkIf.rd_burstcount !== BURST_CNT_WIDTH'(i + 1) || snkIf.rd_byteenable !== expBe) begin
            errorCount++; $display("[TB] FAIL idle_rd_fields[%0d] got bc=%0d be=%h want bc=%0d be=%h",
                                   i, snkIf.rd_burstcount, snkIf.rd_byteenable, i + 1, expBe);
         end
         checkCount++;
         if (srcIf.rd_waitrequest !== 1'b0) begin
            errorCount++; $display("[TB] FAIL idle_rd_waitreq[%0d] got %b want 0", i, srcIf.rd_waitrequest);
         end
      end
      srcIf.rd_read = 1'b0;
      cycle();
      checkCount++;
      if (snkIf.rd_read !== 1'b0) begin
         errorCount++; $display("[TB] FAIL idle_rd_drained got %b want 0", snkIf.rd_read);
      end
   endtask

   task automatic test_wr_backpressure();
      logic expWrq;
      applyIdle();
      snkIf.wr_waitrequest = 1'b1;
      srcIf.wr_address     = 32'h200;
      srcIf.wr_burstcount  = 7'd1;
      srcIf.wr_byteenable  = '1;
      for (int i = 0; i < 8; i++) begin
         srcIf.wr_write     = 1'b1;
         srcIf.wr_writedata = DATA_WIDTH'(32'hA0 + i);
         cycle();
         expWrq = ((i + 1) >= THRESH);
         checkCount++;
         if (srcIf.wr_waitrequest !== expWrq) begin
            errorCount++; $display("[TB] FAIL bp_fill_waitreq[%0d] got %b want %b", i, srcIf.wr_waitrequest, expWrq);
         end
         checkCount++;
         if (snkIf.wr_write !== 1'b1 || snkIf.wr_writedata !== DATA_WIDTH'(32'hA0)) begin
            errorCount++; $display("[TB] FAIL bp_head_hold[%0d] got write=%b data=%h want write=1 data=a0",
                                   i, snkIf.wr_write, snkIf.wr_writedata);
         end
      end
      // Full: push one beat while the sink takes one
      srcIf.wr_writedata   = DATA_WIDTH'(32'hA8);
      snkIf.wr_waitrequest = 1'b0;
      cycle();
      srcIf.wr_write = 1'b0;
      checkCount++;
      if (srcIf.wr_waitrequest !== 1'b1 || wr_overflow !== 1'b0) begin
         errorCount++; $display("[TB] FAIL full_pushpop got waitreq=%b ovf=%b want waitreq=1 ovf=0",
                                srcIf.wr_waitrequest, wr_overflow);
      end
      for (int j = 1; j <= 8; j++) begin
         checkCount++;
         if (snkIf.wr_write !== 1'b1 || snkIf.wr_writedata !== DATA_WIDTH'(32'hA0 + j)) begin
            errorCount++; $display("[TB] FAIL bp_drain[%0d] got write=%b data=%h want write=1 data=%h",
                                   j, snkIf.wr_write, snkIf.wr_writedata, 32'hA0 + j);
         end
         cycle();
         expWrq = ((8 - j) >= THRESH);
         checkCount++;
         if (srcIf.wr_waitrequest !== expWrq) begin
            errorCount++; $display("[TB] FAIL bp_drain_waitreq[%0d] got %b want %b", j, srcIf.wr_waitrequest, expWrq);
         end
      end
      checkCount++;
      if (snkIf.wr_write !== 1'b0) begin
         errorCount++; $display("[TB] FAIL bp_empty got %b want 0", snkIf.wr_write);
      end
   endtask

   task automatic test_burst_write();
      int rx;
      applyIdle();
      rx = 0;
      srcIf.wr_address    = 32'h300;
      srcIf.wr_burstcount = 7'd4;
      srcIf.wr_byteenable = '1;
      for (int c = 0; c < 16; c++) begin
         srcIf.wr_write       = (c < 4);
         srcIf.wr_writedata   = DATA_WIDTH'(32'hB0 + c);
         snkIf.wr_waitrequest = ((c % 2) == 0);
         if (snkIf.wr_write && !snkIf.wr_waitrequest) begin
            checkCount++;
            if (snkIf.wr_address !== 32'h300 || snkIf.wr_burstcount !== 7'd4 ||
                snkIf.wr_writedata !== DATA_WIDTH'(32'hB0 + rx)) begin
               errorCount++; $display("[TB] FAIL burst_beat[%0d] got addr=%h bc=%0d data=%h want addr=300 bc=4 data=%h",
                                      rx, snkIf.wr_address, snkIf.wr_burstcount, snkIf.wr_writedata, 32'hB0 + rx);
            end
            rx++;
         end
         cycle();
      end
      checkCount++;
      if (rx !== 4 || snkIf.wr_write !== 1'b0) begin
         errorCount++; $display("[TB] FAIL burst_count got beats=%0d write=%b want beats=4 write=0", rx, snkIf.wr_write);
      end
   endtask

   task automatic test_overflow();
      applyIdle();
      snkIf.wr_waitrequest = 1'b1;
      srcIf.wr_address     = 32'h600;
      srcIf.wr_burstcount  = 7'd1;
      for (int i = 0; i < 8; i++) begin
         srcIf.wr_write     = 1'b1;
         srcIf.wr_writedata = DATA_WIDTH'(32'hC0 + i);
         cycle();
      end
`ifdef OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN
      srcIf.wr_writedata = DATA_WIDTH'(32'hEE);
      cycle();
      srcIf.wr_write = 1'b0;
      checkCount++;
      if (wr_overflow !== 1'b1 || rd_overflow !== 1'b0) begin
         errorCount++; $display("[TB] FAIL ovf_set got wr=%b rd=%b want wr=1 rd=0", wr_overflow, rd_overflow);
      end
`else
      srcIf.wr_write = 1'b0;
      checkCount++;
      if (wr_overflow !== 1'b0 || rd_overflow !== 1'b0) begin
         errorCount++; $display("[TB] FAIL ovf_tied got wr=%b rd=%b want wr=0 rd=0", wr_overflow, rd_overflow);
      end
`endif
      snkIf.wr_waitrequest = 1'b0;
      for (int j = 0; j < 8; j++) begin
         checkCount++;
         if (snkIf.wr_write !== 1'b1 || snkIf.wr_writedata !== DATA_WIDTH'(32'hC0 + j)) begin
            errorCount++; $display("[TB] FAIL ovf_drain[%0d] got write=%b data=%h want write=1 data=%h",
                                   j, snkIf.wr_write, snkIf.wr_writedata, 32'hC0 + j);
         end
         cycle();
      end
      checkCount++;
      if (snkIf.wr_write !== 1'b0) begin
         errorCount++; $display("[TB] FAIL ovf_empty got %b want 0", snkIf.wr_write);
      end
`ifdef OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN
      checkCount++;
      if (wr_overflow !== 1'b1) begin
         errorCount++; $display("[TB] FAIL ovf_sticky got %b want 1", wr_overflow);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      checkCount++;
      if (wr_overflow !== 1'b0) begin
         errorCount++; $display("[TB] FAIL ovf_cleared got %b want 0", wr_overflow);
      end
`else
      checkCount++;
      if (wr_overflow !== 1'b0) begin
         errorCount++; $display("[TB] FAIL ovf_stays_zero got %b want 0", wr_overflow);
      end
`endif
   endtask

   task automatic test_reset_midop();
      logic [DATA_WIDTH-1:0] pattern;
      applyIdle();
      pattern = {8{64'h5A5A_0123_4567_89AB}};
      snkIf.rd_waitrequest = 1'b1;
      srcIf.rd_burstcount  = 7'd1;
      for (int i = 0; i < 5; i++) begin
         srcIf.rd_read    = 1'b1;
         srcIf.rd_address = ADDR_WIDTH'(32'h400 + i);
         cycle();
      end
      srcIf.rd_read = 1'b0;
      checkCount++;
      if (snkIf.rd_read !== 1'b1 || srcIf.rd_waitrequest !== 1'b1) begin
         errorCount++; $display("[TB] FAIL midop_queued got read=%b waitreq=%b want read=1 waitreq=1",
                                snkIf.rd_read, srcIf.rd_waitrequest);
      end
      reset = 1'b1;
      snkIf.rd_readdata      = pattern;
      snkIf.rd_readdatavalid = 1'b1;
      cycle();
      checkCount++;
      if (snkIf.rd_read !== 1'b0 || srcIf.rd_waitrequest !== 1'b1 || srcIf.wr_waitrequest !== 1'b1) begin
         errorCount++; $display("[TB] FAIL midop_in_reset got read=%b rdwrq=%b wrwrq=%b want 0 1 1",
                                snkIf.rd_read, srcIf.rd_waitrequest, srcIf.wr_waitrequest);
      end
      checkCount++;
      if (srcIf.rd_readdatavalid !== 1'b1 || srcIf.rd_readdata !== pattern) begin
         errorCount++; $display("[TB] FAIL midop_resp_pass got valid=%b data=%h want valid=1 data=%h",
                                srcIf.rd_readdatavalid, srcIf.rd_readdata, pattern);
      end
      reset = 1'b0;
      snkIf.rd_readdatavalid = 1'b0;
      snkIf.rd_waitrequest   = 1'b0;
      cycle();
      checkCount++;
      if (srcIf.rd_waitrequest !== 1'b0 || snkIf.rd_read !== 1'b0) begin
         errorCount++; $display("[TB] FAIL midop_released got waitreq=%b read=%b want 0 0",
                                srcIf.rd_waitrequest, snkIf.rd_read);
      end
      srcIf.rd_read    = 1'b1;
      srcIf.rd_address = 32'h555;
      cycle();
      srcIf.rd_read = 1'b0;
      checkCount++;
      if (snkIf.rd_read !== 1'b1 || snkIf.rd_address !== 32'h555) begin
         errorCount++; $display("[TB] FAIL midop_fresh got read=%b addr=%h want read=1 addr=555",
                                snkIf.rd_read, snkIf.rd_address);
      end
      cycle();
      checkCount++;
      if (snkIf.rd_read !== 1'b0) begin
         errorCount++; $display("[TB] FAIL midop_fresh_drain got %b want 0", snkIf.rd_read);
      end
   endtask

   // Scenario sequence
   initial begin
      reset = 1'b1;
      applyIdle();
      test_reset();
      test_passthrough();
      test_idle_reads();
      test_wr_backpressure();
      test_burst_write();
      test_overflow();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/ofs_plat_avalon_mem_rdwr_allowance_sink.md
# ofs_plat_avalon_mem_rdwr_allowance_sink

Terminates an Avalon rdwr register pipeline that runs under a waitrequest allowance and drives a strict, zero-allowance Avalon rdwr sink. Read requests and write beats are buffered in independent per-channel FIFOs. Source-side waitrequest is issued as an almost-full signal, and the sink side is held to the normal waitrequest rule. Responses pass straight through. The block sits directly downstream of the register-stage pipeline, at the memory/device end.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 512, data width; byteenable is DATA_WIDTH/8
- BURST_CNT_WIDTH, 7, burstcount width
- ALLOWANCE, 4, beats the source may still issue after waitrequest asserts; must be ≥ the upstream waitrequest stages
- DEPTH, 8, FIFO entries per channel; power of two, ≥ ALLOWANCE+1
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- src_rd_read, src_rd_address, src_rd_burstcount, src_rd_byteenable  in  1/ADDR/BCNT/BE  read request
- src_rd_waitrequest  out  1  almost-full, registered
- src_rd_readdata, src_rd_readdatavalid  out  DATA/1  read response
- src_wr_write, src_wr_address, src_wr_burstcount, src_wr_writedata, src_wr_byteenable  in  1/ADDR/BCNT/DATA/BE  write beat
- src_wr_waitrequest  out  1  almost-full, registered
- src_wr_writeresponsevalid  out  1  write response
- snk_rd_read, snk_rd_address, snk_rd_burstcount, snk_rd_byteenable  out  1/ADDR/BCNT/BE  strict read request
- snk_rd_waitrequest  in  1  strict waitrequest
- snk_rd_readdata, snk_rd_readdatavalid  in  DATA/1  read response
- snk_wr_write, snk_wr_address, snk_wr_burstcount, snk_wr_writedata, snk_wr_byteenable  out  1/ADDR/BCNT/DATA/BE  strict write beat
- snk_wr_waitrequest  in  1  strict waitrequest
- snk_wr_writeresponsevalid  in  1  write response
- rd_overflow, wr_overflow  out  1  sticky overflow flags (see Configuration)

## Operation
- Push rule: a source read or write is accepted whenever src_rd_read or src_wr_write is high, regardless of waitrequest. Each burst write data beat is one FIFO entry. Each read request is one FIFO entry.
- Occupancy counter per channel is 0..DEPTH, log2(DEPTH)+1 bits. Next value = count + push − pop.
- Waitrequest: src_*_waitrequest register ← (next count ≥ DEPTH − ALLOWANCE). This bounds occupancy to at most DEPTH.
- Sink side: snk_*_read/write = FIFO non-empty, and the fields come from the FIFO head. A pop occurs when the request is asserted and snk_*_waitrequest is low. The head is held stable while waitrequest is high.
- Channels are fully independent. There is no read/write ordering.
- Responses: readdata, readdatavalid and writeresponsevalid are wired combinationally from snk to src.
- Simultaneous push and pop: allowed at any occupancy, including full (count unchanged) and empty with no bypass (count becomes 1, the pop does not occur).
- Pointers wrap modulo DEPTH.

## Timing
- Latency from source accept to snk request asserted: 1 cycle, because storage is registered and there is no bypass.
- src_*_waitrequest reflects the occupancy at the end of the previous cycle.
- Reset values: src_*_waitrequest=1, snk_*_read/write=0, counts=0, overflow=0. Source requests presented during reset are ignored.
- First cycle after reset deasserts: src_*_waitrequest=0.
- Reset mid-operation: all FIFO contents are discarded. Responses still pass through.

## Configuration
- OFS_PLAT_AVALON_ALLOWANCE_SINK_CHECK_EN defined: a push with count==DEPTH and no pop is dropped, and rd_overflow/wr_overflow set and hold until reset.
- Not defined: rd_overflow and wr_overflow are tied 0, no detection logic is built, and a push on full is a protocol violation.

## Structure
- Package ofs_plat_avalon_allowance_sink_pkg holds the threshold function (DEPTH − ALLOWANCE) and an elaboration-time parameter check (DEPTH power of two, DEPTH > ALLOWANCE).
- Sub-module ofs_plat_avalon_allowance_fifo is a width-parameterized FIFO that exposes count and the registered almost-full output. It is instantiated once per channel, with read entry = {address, burstcount, byteenable} and write entry = {address, burstcount, writedata, byteenable}.

## Test plan
- Idle sink: issue 4 reads at A=0x100..0x103 with ALLOWANCE=4, DEPTH=8 → snk_rd_read rises 1 cycle after the first accept, addresses are in order, and src_rd_waitrequest stays 0.
- snk_wr_waitrequest held high: stream writes → src_wr_waitrequest=1 the cycle after count reaches 4; 4 more beats are accepted; count=8; the sink receives all 8 beats in order once waitrequest drops.
- Burst write with burstcount=4 under alternating snk_wr_waitrequest → 4 beats delivered, address/burstcount repeated per beat, data in order.
- At count==8, simultaneous push and pop → count stays 8, no overflow, order preserved.
- With the CHECK_EN macro defined, a 9th beat is pushed while full → beat dropped and wr_overflow=1 until reset. Without the macro defined, wr_overflow stays 0.
- Reset asserted with 5 entries queued → next cycle snk_rd_read=0 and waitrequest=1; one cycle after release, waitrequest=0 and count=0.
